// File: rtl/uart_pid_pkg.sv
// ============================================================================
// Module  : uart_pid_pkg
// Brief   : Shared constants and state encoding for the PID telemetry link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pid_pkg;

  localparam logic [7:0] START_DEL = 8'hAA;
  localparam logic [7:0] END_DEL   = 8'h55;
  localparam logic [7:0] TEST_PID  = 8'h42;
  localparam logic [7:0] DATA_PID  = 8'h69;
  localparam int         FRAME_LEN = 7;

  // Start, PID and end delimiter surround the payload.
  localparam int         PAYLOAD_BYTES = FRAME_LEN - 3;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_PID  = 2'd1,
    S_DATA = 2'd2,
    S_END  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_pid_parser.sv
// ============================================================================
// Module  : uart_rx_pid_parser
// Brief   : Deframes AA/PID/4-byte LE payload/55 frames from a UART RX core.
//           Optional inter-byte timeout: define UART_RX_PID_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_pid_parser
  import uart_pid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [31:0]          rx_float,
  output logic                 rx_float_valid,
  output logic                 rx_test,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          buf_q, buf_d;
  logic                 pend_test_q, pend_test_d;
  logic [31:0]          rx_float_q, rx_float_d;
  logic                 rx_test_q, rx_test_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 timeout;

`ifdef UART_RX_PID_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // A byte arriving on the expiry cycle wins: rx_valid clears the count first.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (!rx_valid && state_q != S_HUNT) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    pend_test_d = pend_test_q;
    rx_float_d  = rx_float_q;
    rx_test_d   = rx_test_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        S_HUNT: begin
          if (rx_data == START_DEL) state_d = S_PID;
        end
        S_PID: begin
          if (rx_data == TEST_PID || rx_data == DATA_PID) begin
            pend_test_d = (rx_data == TEST_PID);
            idx_d       = 2'd0;
            state_d     = S_DATA;
          end else if (rx_data != START_DEL) begin
            ferr_d  = 1'b1;
            state_d = S_HUNT;
          end
        end
        S_DATA: begin
          buf_d[8*idx_q +: 8] = rx_data;
          idx_d               = idx_q + 2'd1;
          if (idx_q == 2'(PAYLOAD_BYTES - 1)) state_d = S_END;
        end
        S_END: begin
          if (rx_data == END_DEL) begin
            rx_float_d = buf_q;
            rx_test_d  = pend_test_q;
            valid_d    = 1'b1;
            state_d    = S_HUNT;
          end else begin
            ferr_d  = 1'b1;
            state_d = (rx_data == START_DEL) ? S_PID : S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end else if (timeout) begin
      ferr_d  = 1'b1;
      state_d = S_HUNT;
      idx_d   = 2'd0;
      buf_d   = '0;
    end
    err_count_d = err_count_q;
    if (ferr_d && err_count_q != {ERR_CNT_W{1'b1}}) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HUNT;
      idx_q       <= 2'd0;
      buf_q       <= '0;
      pend_test_q <= 1'b0;
      rx_float_q  <= '0;
      rx_test_q   <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      pend_test_q <= pend_test_d;
      rx_float_q  <= rx_float_d;
      rx_test_q   <= rx_test_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      err_count_q <= err_count_d;
    end
  end

  assign rx_float       = rx_float_q;
  assign rx_test        = rx_test_q;
  assign rx_float_valid = valid_q;
  assign frame_err      = ferr_q;
  assign err_count      = err_count_q;
  assign busy           = (state_q != S_HUNT);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_pid_parser.sv
// ============================================================================
// Module  : tb_uart_rx_pid_parser
// Brief   : Table-driven self-checking bench for uart_rx_pid_parser.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_pid_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] rx_float;
  logic        rx_float_valid;
  logic        rx_test;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_rx_pid_parser #(
    .TIMEOUT_CYCLES(16),
    .ERR_CNT_W     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_float      (rx_float),
    .rx_float_valid(rx_float_valid),
    .rx_test       (rx_test),
    .frame_err     (frame_err),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [7:0]  d;
    logic        e_val;
    logic        e_ferr;
    logic [31:0] e_float;
    logic        e_test;
    logic [7:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic val, input logic fe, input logic [31:0] f,
                              input logic t, input logic [7:0] c, input logic b);
    vec_t x;
    x.rst_n = r; x.v = v; x.d = d; x.e_val = val; x.e_ferr = fe;
    x.e_float = f; x.e_test = t; x.e_cnt = c; x.e_busy = b;
    vq.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    int first_err;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_float", 0, rx_float, 32'h0);
    chk("reset_flags", 0, {29'h0, rx_float_valid, frame_err, busy}, 32'h0);
    chk("reset_cnt", 0, {24'h0, err_count}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    //  rst v  byte  val fe float          t  cnt   busy
    // Good data frame
    add(1, 1, 8'hAA, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h69, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h78, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h56, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h34, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h12, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h55, 1, 0, 32'h12345678, 0, 8'd0, 0);
    // Back-to-back test frame then data frame
    add(1, 1, 8'hAA, 0, 0, 32'h12345678, 0, 8'd0, 1);
    add(1, 1, 8'h42, 0, 0, 32'h12345678, 0, 8'd0, 1);
    add(1, 1, 8'hEF, 0, 0, 32'h12345678, 0, 8'd0, 1);
    add(1, 1, 8'hBE, 0, 0, 32'h12345678, 0, 8'd0, 1);
    add(1, 1, 8'hAD, 0, 0, 32'h12345678, 0, 8'd0, 1);
    add(1, 1, 8'hDE, 0, 0, 32'h12345678, 0, 8'd0, 1);
    add(1, 1, 8'h55, 1, 0, 32'hDEADBEEF, 1, 8'd0, 0);
    add(1, 1, 8'hAA, 0, 0, 32'hDEADBEEF, 1, 8'd0, 1);
    add(1, 1, 8'h69, 0, 0, 32'hDEADBEEF, 1, 8'd0, 1);
    add(1, 1, 8'h01, 0, 0, 32'hDEADBEEF, 1, 8'd0, 1);
    add(1, 1, 8'h00, 0, 0, 32'hDEADBEEF, 1, 8'd0, 1);
    add(1, 1, 8'h00, 0, 0, 32'hDEADBEEF, 1, 8'd0, 1);
    add(1, 1, 8'h00, 0, 0, 32'hDEADBEEF, 1, 8'd0, 1);
    add(1, 1, 8'h55, 1, 0, 32'h00000001, 0, 8'd0, 0);
    // Junk, AA AA resync, delimiter values as payload
    add(1, 1, 8'h00, 0, 0, 32'h00000001, 0, 8'd0, 0);
    add(1, 1, 8'h13, 0, 0, 32'h00000001, 0, 8'd0, 0);
    add(1, 1, 8'hAA, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'hAA, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'h69, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'h55, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'hAA, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'h55, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'hAA, 0, 0, 32'h00000001, 0, 8'd0, 1);
    add(1, 1, 8'h55, 1, 0, 32'hAA55AA55, 0, 8'd0, 0);
    add(1, 0, 8'h00, 0, 0, 32'hAA55AA55, 0, 8'd0, 0);
    // Bad PID, then bad end delimiter that resyncs
    add(1, 1, 8'hAA, 0, 0, 32'hAA55AA55, 0, 8'd0, 1);
    add(1, 1, 8'h77, 0, 1, 32'hAA55AA55, 0, 8'd1, 0);
    add(1, 1, 8'hAA, 0, 0, 32'hAA55AA55, 0, 8'd1, 1);
    add(1, 1, 8'h69, 0, 0, 32'hAA55AA55, 0, 8'd1, 1);
    add(1, 1, 8'h01, 0, 0, 32'hAA55AA55, 0, 8'd1, 1);
    add(1, 1, 8'h02, 0, 0, 32'hAA55AA55, 0, 8'd1, 1);
    add(1, 1, 8'h03, 0, 0, 32'hAA55AA55, 0, 8'd1, 1);
    add(1, 1, 8'h04, 0, 0, 32'hAA55AA55, 0, 8'd1, 1);
    add(1, 1, 8'hAA, 0, 1, 32'hAA55AA55, 0, 8'd2, 1);
    add(1, 1, 8'h69, 0, 0, 32'hAA55AA55, 0, 8'd2, 1);
    add(1, 1, 8'h05, 0, 0, 32'hAA55AA55, 0, 8'd2, 1);
    add(1, 1, 8'h06, 0, 0, 32'hAA55AA55, 0, 8'd2, 1);
    add(1, 1, 8'h07, 0, 0, 32'hAA55AA55, 0, 8'd2, 1);
    add(1, 1, 8'h08, 0, 0, 32'hAA55AA55, 0, 8'd2, 1);
    add(1, 1, 8'h55, 1, 0, 32'h08070605, 0, 8'd2, 0);
    // Reset mid-frame, then a clean frame
    add(1, 1, 8'hAA, 0, 0, 32'h08070605, 0, 8'd2, 1);
    add(1, 1, 8'h69, 0, 0, 32'h08070605, 0, 8'd2, 1);
    add(1, 1, 8'h11, 0, 0, 32'h08070605, 0, 8'd2, 1);
    add(1, 1, 8'h22, 0, 0, 32'h08070605, 0, 8'd2, 1);
    add(0, 0, 8'h00, 0, 0, 32'h00000000, 0, 8'd0, 0);
    add(1, 1, 8'hAA, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h69, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h44, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h33, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h22, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h11, 0, 0, 32'h00000000, 0, 8'd0, 1);
    add(1, 1, 8'h55, 1, 0, 32'h11223344, 0, 8'd0, 0);
    add(1, 0, 8'h00, 0, 0, 32'h11223344, 0, 8'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst      = vq[i].rst_n;
      rx_valid = vq[i].v;
      rx_data  = vq[i].d;
      @(negedge clk);
      chk("valid", i, {31'h0, rx_float_valid}, {31'h0, vq[i].e_val});
      chk("frame_err", i, {31'h0, frame_err}, {31'h0, vq[i].e_ferr});
      chk("rx_float", i, rx_float, vq[i].e_float);
      chk("rx_test", i, {31'h0, rx_test}, {31'h0, vq[i].e_test});
      chk("err_count", i, {24'h0, err_count}, {24'h0, vq[i].e_cnt});
      chk("busy", i, {31'h0, busy}, {31'h0, vq[i].e_busy});
    end
    rst      = 1'b1;
    rx_valid = 1'b0;

    // Saturating error counter: 260 bad-PID frames
    for (int i = 0; i < 260; i++) begin
      send(8'hAA);
      send(8'h77);
      chk("sat_ferr", i, {31'h0, frame_err}, 32'h1);
      chk("sat_cnt", i, {24'h0, err_count}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    chk("sat_hold_float", 0, rx_float, 32'h11223344);
    chk("sat_hold_valid", 0, {31'h0, rx_float_valid}, 32'h0);

`ifdef UART_RX_PID_TIMEOUT_EN
    send(8'hAA);
    send(8'h69);
    send(8'h01);
    first_err = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_err && first_err == 0) first_err = k;
      if (k == 16) chk("to_busy", k, {31'h0, busy}, 32'h0);
    end
    chk("to_cycle", 0, 32'(first_err), 32'd16);
    chk("to_cnt_sat", 0, {24'h0, err_count}, 32'd255);
    chk("to_float", 0, rx_float, 32'h11223344);
`else
    send(8'hAA);
    send(8'h69);
    send(8'h01);
    first_err = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_err) first_err = k;
    end
    chk("wait_busy", 0, {31'h0, busy}, 32'h1);
    chk("wait_noerr", 0, 32'(first_err), 32'd0);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h55);
    chk("wait_valid", 0, {31'h0, rx_float_valid}, 32'h1);
    chk("wait_float", 0, rx_float, 32'h04030201);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
